alu_operand_stage: RTL



---
 rtl/alu_operand_stage_pkg.sv | 50 +++++
 rtl/alu_op_decode.sv | 58 +++++
 rtl/alu_operand_stage.sv | 132 +++++++++++++
 3 files changed

// File: rtl/alu_operand_stage_pkg.sv
// rtl/alu_operand_stage_pkg.sv - shared ALU control encodings and RV32I decode constants
package alu_operand_stage_pkg;

  typedef enum logic [3:0] {
    ALU_NONE = 4'b0000,
    ALU_AND  = 4'b0001,
    ALU_OR   = 4'b0010,
    ALU_XOR  = 4'b0011,
    ALU_SLL  = 4'b0101,
    ALU_SRL  = 4'b0110,
    ALU_SRA  = 4'b0111,
    ALU_ADD  = 4'b1000,
    ALU_SUB  = 4'b1100,
    ALU_SLT  = 4'b1101,
    ALU_SLTU = 4'b1111
  } alu_control_t;

  typedef enum logic [1:0] {A_ZERO, A_RS1, A_PC} a_sel_t;
  typedef enum logic [1:0] {B_ZERO, B_RS2, B_IMM, B_SHAMT} b_sel_t;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

  localparam logic [2:0] F3_ADD  = 3'b000;
  localparam logic [2:0] F3_SLL  = 3'b001;
  localparam logic [2:0] F3_SLT  = 3'b010;
  localparam logic [2:0] F3_SLTU = 3'b011;
  localparam logic [2:0] F3_XOR  = 3'b100;
  localparam logic [2:0] F3_SR   = 3'b101;
  localparam logic [2:0] F3_OR   = 3'b110;
  localparam logic [2:0] F3_AND  = 3'b111;

  // funct7b5 selects SUB only for register-register ops; it always selects SRA for shifts.
  function automatic alu_control_t funct3_to_control(input logic [2:0] f3, input logic f7b5,
                                                     input logic is_op);
    case (f3)
      F3_ADD:  return (is_op && f7b5) ? ALU_SUB : ALU_ADD;
      F3_SLL:  return ALU_SLL;
      F3_SLT:  return ALU_SLT;
      F3_SLTU: return ALU_SLTU;
      F3_XOR:  return ALU_XOR;
      F3_SR:   return f7b5 ? ALU_SRA : ALU_SRL;
      F3_OR:   return ALU_OR;
      default: return ALU_AND;
    endcase
  endfunction

endpackage

// File: rtl/alu_op_decode.sv
// rtl/alu_op_decode.sv - combinational opcode/funct decode to ALU control and operand selects
module alu_op_decode
  import alu_operand_stage_pkg::*;
#(
  parameter int REG_ADDR_W = 5
) (
  input  logic [6:0]            opcode,
  input  logic [2:0]            funct3,
  input  logic                  funct7b5,
  input  logic [REG_ADDR_W-1:0] rd,
  output alu_control_t          control,
  output a_sel_t                a_sel,
  output b_sel_t                b_sel,
  output logic                  rd_we,
  output logic                  illegal
);

  always_comb begin
    control = ALU_NONE;
    a_sel   = A_ZERO;
    b_sel   = B_ZERO;
    illegal = 1'b0;
    case (opcode)
      OPC_OP: begin
        a_sel   = A_RS1;
        b_sel   = B_RS2;
        control = funct3_to_control(funct3, funct7b5, 1'b1);
        illegal = funct7b5 && (funct3 != F3_ADD) && (funct3 != F3_SR);
      end
      OPC_OP_IMM: begin
        a_sel   = A_RS1;
        // imm[10] carries funct7b5 for shifts, so only the shamt field may reach the ALU
        b_sel   = ((funct3 == F3_SLL) || (funct3 == F3_SR)) ? B_SHAMT : B_IMM;
        control = funct3_to_control(funct3, funct7b5, 1'b0);
        illegal = (funct3 == F3_SLL) && funct7b5;
      end
      OPC_LUI: begin
        a_sel   = A_ZERO;
        b_sel   = B_IMM;
        control = ALU_ADD;
      end
      OPC_AUIPC: begin
        a_sel   = A_PC;
        b_sel   = B_IMM;
        control = ALU_ADD;
      end
      default: illegal = 1'b1;
    endcase
    if (illegal) begin
      control = ALU_NONE;
      a_sel   = A_ZERO;
      b_sel   = B_ZERO;
    end
  end

  assign rd_we = !illegal && (rd != '0);

endmodule

// File: rtl/alu_operand_stage.sv
// rtl/alu_operand_stage.sv - registered ALU operand stage with a 2-entry skid buffer
module alu_operand_stage
  import alu_operand_stage_pkg::*;
#(
  parameter int N          = 32,
  parameter int REG_ADDR_W = 5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [6:0]            in_opcode,
  input  logic [2:0]            in_funct3,
  input  logic                  in_funct7b5,
  input  logic [REG_ADDR_W-1:0] in_rd,
  input  logic [N-1:0]          in_pc,
  input  logic [N-1:0]          in_rs1,
  input  logic [N-1:0]          in_rs2,
  input  logic [N-1:0]          in_imm,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [N-1:0]          out_a,
  output logic [N-1:0]          out_b,
  output logic [3:0]            out_control,
  output logic [REG_ADDR_W-1:0] out_rd,
  output logic                  out_rd_we,
  output logic                  out_illegal
);

  alu_control_t dec_control;
  a_sel_t       a_sel;
  b_sel_t       b_sel;
  logic         dec_rd_we;
  logic         dec_illegal;
  logic [N-1:0] op_a;
  logic [N-1:0] op_b;

  alu_op_decode #(.REG_ADDR_W(REG_ADDR_W)) u_decode (
    .opcode   (in_opcode),
    .funct3   (in_funct3),
    .funct7b5 (in_funct7b5),
    .rd       (in_rd),
    .control  (dec_control),
    .a_sel    (a_sel),
    .b_sel    (b_sel),
    .rd_we    (dec_rd_we),
    .illegal  (dec_illegal)
  );

  always_comb begin
    case (a_sel)
      A_RS1:   op_a = in_rs1;
      A_PC:    op_a = in_pc;
      default: op_a = '0;
    endcase
    case (b_sel)
      B_RS2:   op_b = in_rs2;
      B_IMM:   op_b = in_imm;
      B_SHAMT: op_b = {{(N-5){1'b0}}, in_imm[4:0]};
      default: op_b = '0;
    endcase
  end

  logic                  skid_full;
  logic [N-1:0]          skid_a;
  logic [N-1:0]          skid_b;
  logic [3:0]            skid_control;
  logic [REG_ADDR_W-1:0] skid_rd;
  logic                  skid_rd_we;
  logic                  skid_illegal;

  logic accept;
  logic out_free;

  assign in_ready = !skid_full;
  assign accept   = in_valid && in_ready;
  assign out_free = !out_valid || out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid    <= 1'b0;
      out_a        <= '0;
      out_b        <= '0;
      out_control  <= 4'b0000;
      out_rd       <= '0;
      out_rd_we    <= 1'b0;
      out_illegal  <= 1'b0;
      skid_full    <= 1'b0;
      skid_a       <= '0;
      skid_b       <= '0;
      skid_control <= 4'b0000;
      skid_rd      <= '0;
      skid_rd_we   <= 1'b0;
      skid_illegal <= 1'b0;
    end else if (flush) begin
      out_valid <= 1'b0;
      skid_full <= 1'b0;
    end else if (out_free) begin
      // skid_full implies in_ready=0, so draining the skid never races a new accept
      if (skid_full) begin
        out_valid   <= 1'b1;
        out_a       <= skid_a;
        out_b       <= skid_b;
        out_control <= skid_control;
        out_rd      <= skid_rd;
        out_rd_we   <= skid_rd_we;
        out_illegal <= skid_illegal;
        skid_full   <= 1'b0;
      end else if (accept) begin
        out_valid   <= 1'b1;
        out_a       <= op_a;
        out_b       <= op_b;
        out_control <= dec_control;
        out_rd      <= in_rd;
        out_rd_we   <= dec_rd_we;
        out_illegal <= dec_illegal;
      end else begin
        out_valid <= 1'b0;
      end
    end else if (accept) begin
      skid_full    <= 1'b1;
      skid_a       <= op_a;
      skid_b       <= op_b;
      skid_control <= dec_control;
      skid_rd      <= in_rd;
      skid_rd_we   <= dec_rd_we;
      skid_illegal <= dec_illegal;
    end
  end

endmodule
